lif_neuron: RTL and testbench
=============================

// Module: lif_neuron
// PURPOSE
//  Parametrised leaky integrate-and-fire neuron; next generation of the neurochip tile cell.
//  - N_DEND signed-weight dendrites (excitatory and inhibitory).
//  - Programmable threshold and refractory period; leak driven by a selectable line of the shared decay bus.
//  - Config loaded through a daisy-chained serial shift register (bs_in -> bs_out); instantiated in arrays inside the brain top.
// PARAMETERS
//  N_DEND   3  number of dendrite inputs
//  W_W      3  weight width, two's complement
//  W_U      5  membrane/threshold width, unsigned
//  N_DECAY  8  decay bus width; W_SEL = $clog2(N_DECAY) (localparam)
//  W_REF    2  refractory-period field width
//  CFG_BITS = N_DEND*W_W + W_U + W_REF + W_SEL (localparam; 19 at defaults)
// PORTS
//  clk       in   1         clock; all logic on posedge
//  nn_reset  in   1         synchronous active-high reset, clears all state incl. config
//  conf_en   in   1         1 = shift config chain, neuron frozen
//  bs_in     in   1         config serial in
//  bs_out    out  1         config serial out (= cfg[CFG_BITS-1])
//  nn_clear  in   1         sync clear of membrane/refractory only, config kept
//  dend      in   N_DEND    dendrite spike inputs
//  dbus      in   N_DECAY   shared decay clock bus
//  axon      out  1         registered one-cycle spike
//  u_out     out  W_U       membrane value (debug/observability)
// BEHAVIOUR
//  Priority: nn_reset > nn_clear > conf_en > integrate.
//  Reset: cfg, U, ref_cnt, axon, decay-edge flop all 0; bs_out=0, u_out=0, axon=0.
//  Config: when conf_en=1, cfg <= {cfg[CFG_BITS-2:0], bs_in} every cycle.
//   - Field map, LSB up: tsel[W_SEL], ref_period[W_REF], thresh[W_U], w[0]..w[N_DEND-1] (w[N-1] at top).
//   - First bit shifted in = MSB of w[N-1]. bs_out reproduces bs_in delayed CFG_BITS cycles.
//   - While conf_en=1: U and ref_cnt hold, axon=0.
//  nn_clear: U<=0, ref_cnt<=0, axon<=0; cfg untouched, shift still occurs if conf_en=1.
//  Decay edge: dprev <= dbus[tsel] every cycle except reset; leak = dbus[tsel] & ~dprev.
//  Integrate (conf_en=0), per cycle:
//   - ref_cnt!=0: ref_cnt--, U held 0, dend ignored, axon<=0.
//   - else:
//     - sum = sum over i of (dend[i] ? sext(w[i]) : 0) in W_U+$clog2(N_DEND)+W_W signed bits.
//     - UL = leak ? U>>1 : U; nxt = Ul + sum.
//     - nxt<0 -> U<=0 (floor, no wrap), axon<=0.
//     - nxt>=thresh -> axon<=1, U<=0, ref_cnt<=ref_period.
//     - else U<=nxt, axon<=0 (nxt<thresh<=2^W_U-1 so fits).
//  Latency: dend sampled at edge t -> axon high during cycle t+1 for exactly one cycle; u_out=0 in same cycle.
//  thresh=0: fires every non-refractory cycle. ref_period=0: can fire on consecutive cycles.
//  Reset/clear mid-config or mid-refractory takes effect next edge, no partial state retained.
// STRUCTURE
//  Package neuro_pkg: field offset constants/functions (OFF_TSEL, OFF_REF, OFF_THR, OFF_W(i)), CFG_BITS calc, saturate/floor helper.
//  Sub-module neuro_cfg_chain: CFG_BITS shift register with reset, parallel field outputs, bs_out.
//  Top: decay edge detect, weighted adder tree, compare/fire, refractory counter.
// TESTING (defaults)
//  Reset: nn_reset=1 one cycle -> axon=0, u_out=0, bs_out=0 next cycle.
//  Chain: shift 19-bit pattern, then 19 zeros -> bs_out replays pattern exactly; U frozen throughout.
//  Fire: w0=+3, thresh=10, ref=0, dbus=0, dend=001 held -> u_out 3,6,9,0; axon=1 only with u_out=0; repeats.
//  Inhibit floor: w1=-4, U=3, dend=010 -> u_out=0 (not 31); dend=011 (w0=+3) from U=3 -> u_out=2.
//  Leak: tsel=2, U=9, dend=0, dbus[2] high 3 cycles -> U=4 once; falls then rises again -> U=2.
//  Refractory/clear: ref=2, after fire dend=001 ignored 2 cycles (U=0), then U=3; nn_clear mid-integration -> U=0, cfg intact.

Source files
------------

// File: rtl/neuro_pkg.sv
// Shared constants and helpers for the LIF neuron tile cell.
// Config chain field map (LSB up): tsel, ref_period, thresh, w[0]..w[N_DEND-1].
// The offset helpers take the field widths as arguments so that any
// parameterisation of lif_neuron can use the same map.
package neuro_pkg;

  localparam int OFF_TSEL = 0;

  function automatic int cfg_bits(input int n_dend, input int w_w, input int w_u,
                                  input int w_ref, input int w_sel);
    return n_dend * w_w + w_u + w_ref + w_sel;
  endfunction

  function automatic int off_ref(input int w_sel);
    return w_sel;
  endfunction

  function automatic int off_thr(input int w_sel, input int w_ref);
    return w_sel + w_ref;
  endfunction

  function automatic int off_w(input int i, input int w_sel, input int w_ref,
                               input int w_u, input int w_w);
    return w_sel + w_ref + w_u + i * w_w;
  endfunction

endpackage

// File: rtl/lif_neuron_if.sv
// Neuron-side signal bundle: config chain, clear, dendrites, decay bus and
// the observable outputs. master = driver (brain top / bench), slave = neuron.
interface lif_neuron_if #(
  parameter int N_DEND  = 3,
  parameter int N_DECAY = 8,
  parameter int W_U     = 5
);
  logic               conf_en;
  logic               bs_in;
  logic               bs_out;
  logic               nn_clear;
  logic [N_DEND-1:0]  dend;
  logic [N_DECAY-1:0] dbus;
  logic               axon;
  logic [W_U-1:0]     u_out;

  modport master (
    output conf_en, bs_in, nn_clear, dend, dbus,
    input  bs_out, axon, u_out
  );

  modport slave (
    input  conf_en, bs_in, nn_clear, dend, dbus,
    output bs_out, axon, u_out
  );
endinterface

// File: rtl/neuro_cfg_chain.sv
// Serial config shift register of one neuron.
// Ports: clk, rst (sync, active high), shift (1 = shift one bit in),
//        bs_in (serial in, lands in bit 0), cfg (parallel contents),
//        bs_out (serial out = top bit, feeds the next neuron in the chain).
module neuro_cfg_chain #(
  parameter int CFG_BITS = 19
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift,
  input  logic                bs_in,
  output logic [CFG_BITS-1:0] cfg,
  output logic                bs_out
);

  always_ff @(posedge clk) begin
    if (rst)        cfg <= '0;
    else if (shift) cfg <= {cfg[CFG_BITS-2:0], bs_in};
  end

  assign bs_out = cfg[CFG_BITS-1];

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with signed-weight dendrites, programmable
// threshold / refractory period and leak driven by a selected decay-bus line.
// Ports: clk, nn_reset (sync, active high, clears everything incl. config),
//        io (lif_neuron_if.slave): conf_en, bs_in, bs_out, nn_clear, dend,
//        dbus, axon (registered one-cycle spike), u_out (membrane value).
module lif_neuron
  import neuro_pkg::*;
#(
  parameter int N_DEND  = 3,
  parameter int W_W     = 3,
  parameter int W_U     = 5,
  parameter int N_DECAY = 8,
  parameter int W_REF   = 2
) (
  input  logic         clk,
  input  logic         nn_reset,
  lif_neuron_if.slave  io
);

  localparam int W_SEL    = $clog2(N_DECAY);
  localparam int CFG_BITS = cfg_bits(N_DEND, W_W, W_U, W_REF, W_SEL);
  // Wide enough for U plus N_DEND weights of either sign without overflow.
  localparam int W_S      = W_U + $clog2(N_DEND) + W_W;

  logic [CFG_BITS-1:0] cfg;

  neuro_cfg_chain #(.CFG_BITS(CFG_BITS)) u_chain (
    .clk    (clk),
    .rst    (nn_reset),
    .shift  (io.conf_en),
    .bs_in  (io.bs_in),
    .cfg    (cfg),
    .bs_out (io.bs_out)
  );

  logic [W_SEL-1:0] tsel;
  logic [W_REF-1:0] ref_period;
  logic [W_U-1:0]   thresh;

  assign tsel       = cfg[OFF_TSEL +: W_SEL];
  assign ref_period = cfg[off_ref(W_SEL) +: W_REF];
  assign thresh     = cfg[off_thr(W_SEL, W_REF) +: W_U];

  // Gated, sign-extended weight per dendrite.
  logic [N_DEND-1:0][W_S-1:0] wx;

  for (genvar i = 0; i < N_DEND; i++) begin : g_dend
    localparam int OFF = off_w(i, W_SEL, W_REF, W_U, W_W);
    logic [W_W-1:0] wr;
    assign wr    = cfg[OFF +: W_W];
    assign wx[i] = io.dend[i] ? {{(W_S-W_W){wr[W_W-1]}}, wr} : '0;
  end

  logic [W_S-1:0] sum;
  always_comb begin
    sum = '0;
    for (int i = 0; i < N_DEND; i++) sum = sum + wx[i];
  end

  logic           dprev;
  logic           dsel;
  logic           leak;
  logic [W_U-1:0] u;
  logic [W_U-1:0] ul;
  logic [W_S-1:0] nxt;
  logic           neg;
  logic           fire;
  logic [W_REF-1:0] ref_cnt;
  logic           axon_q;

  // Leak happens once per rising edge of the selected decay line.
  assign dsel = io.dbus[tsel];
  assign leak = dsel & ~dprev;
  assign ul   = leak ? (u >> 1) : u;
  assign nxt  = {{(W_S-W_U){1'b0}}, ul} + sum;
  assign neg  = nxt[W_S-1];
  // nxt is non-negative here, so an unsigned compare against thresh is exact.
  assign fire = !neg && (nxt >= {{(W_S-W_U){1'b0}}, thresh});

  always_ff @(posedge clk) begin
    if (nn_reset) begin
      dprev   <= 1'b0;
      u       <= '0;
      ref_cnt <= '0;
      axon_q  <= 1'b0;
    end else begin
      dprev <= dsel;
      if (io.nn_clear) begin
        u       <= '0;
        ref_cnt <= '0;
        axon_q  <= 1'b0;
      end else if (io.conf_en) begin
        axon_q <= 1'b0;
      end else if (ref_cnt != '0) begin
        ref_cnt <= ref_cnt - W_REF'(1);
        u       <= '0;
        axon_q  <= 1'b0;
      end else if (neg) begin
        u      <= '0;
        axon_q <= 1'b0;
      end else if (fire) begin
        u       <= '0;
        ref_cnt <= ref_period;
        axon_q  <= 1'b1;
      end else begin
        // Below thresh, so the low W_U bits hold the whole value.
        u      <= nxt[W_U-1:0];
        axon_q <= 1'b0;
      end
    end
  end

  assign io.axon  = axon_q;
  assign io.u_out = u;

endmodule

// File: tb/tb_lif_neuron.sv
// Self-checking bench for lif_neuron at default parameters. A behavioural
// model (integer arithmetic on decoded config fields) steps on every clock
// edge; directed tests also check literal expected sequences.
module tb_lif_neuron;

  logic clk = 1'b0;
  logic nn_reset;
  always #5 clk = ~clk;

  lif_neuron_if #(.N_DEND(3), .N_DECAY(8), .W_U(5)) io ();

  lif_neuron #(.N_DEND(3), .W_W(3), .W_U(5), .N_DECAY(8), .W_REF(2)) dut (
    .clk      (clk),
    .nn_reset (nn_reset),
    .io       (io)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  bit [18:0] m_cfg;
  int        m_u, m_ref;
  bit        m_axon, m_dprev;

  function automatic int fld(input int lo, input int n);
    return (int'(m_cfg) >> lo) & ((1 << n) - 1);
  endfunction

  function automatic int wgt(input int i);
    int v;
    v = fld(10 + 3 * i, 3);
    return (v >= 4) ? v - 8 : v;
  endfunction

  task automatic model_step();
    int  tsel, sum, ul, nxt;
    bit  cur, lk;
    if (nn_reset) begin
      m_cfg = '0; m_u = 0; m_ref = 0; m_axon = 0; m_dprev = 0;
      return;
    end
    tsel = fld(0, 3);
    cur = io.dbus[tsel];
    lk = cur && !m_dprev;
    m_dprev = cur;
    if (io.nn_clear) begin
      m_u = 0; m_ref = 0; m_axon = 0;
      if (io.conf_en) m_cfg = {m_cfg[17:0], io.bs_in};
    end else if (io.conf_en) begin
      m_cfg = {m_cfg[17:0], io.bs_in};
      m_axon = 0;
    end else if (m_ref > 0) begin
      m_ref--; m_u = 0; m_axon = 0;
    end else begin
      sum = 0;
      for (int i = 0; i < 3; i++) if (io.dend[i]) sum += wgt(i);
      ul = lk ? m_u / 2 : m_u;
      nxt = ul + sum;
      if (nxt < 0) begin
        m_u = 0; m_axon = 0;
      end else if (nxt >= fld(5, 5)) begin
        m_u = 0; m_axon = 1; m_ref = fld(3, 2);
      end else begin
        m_u = nxt; m_axon = 0;
      end
    end
  endtask

  // One clock edge: model follows the DUT edge, outputs settle by +1.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic load_cfg(input bit [18:0] c);
    io.conf_en = 1'b1;
    for (int i = 18; i >= 0; i--) begin
      io.bs_in = c[i];
      cycle();
    end
    io.conf_en = 1'b0;
    io.bs_in   = 1'b0;
  endtask

  function automatic bit [18:0] mk_cfg(input int w0, input int w1, input int w2,
                                       input int thr, input int rp, input int ts);
    int v;
    v = ((((((w2 & 7) * 8 + (w1 & 7)) * 8 + (w0 & 7)) * 32 + thr) * 4 + rp) * 8) + ts;
    return 19'(v);
  endfunction

  // Load config then clear membrane state with a quiet decay bus.
  task automatic setup(input int w0, input int w1, input int w2,
                       input int thr, input int rp, input int ts);
    io.dend = '0; io.dbus = '0;
    load_cfg(mk_cfg(w0, w1, w2, thr, rp, ts));
    io.nn_clear = 1'b1;
    cycle();
    io.nn_clear = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nn_reset = 1'b1;
    cycle();
    checks++;
    if (io.axon !== 1'b0 || io.u_out !== 5'd0 || io.bs_out !== 1'b0) begin
      errors++;
      $display("FAIL reset got axon=%b u=%0d bs_out=%b want 0 0 0", io.axon, io.u_out, io.bs_out);
    end
    nn_reset = 1'b0;
  endtask

  task automatic test_fire();
    int exp_u [8] = '{3, 6, 9, 0, 3, 6, 9, 0};
    bit exp_a [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    setup(3, 0, 0, 10, 0, 0);
    io.dend = 3'b001;
    for (int k = 0; k < 8; k++) begin
      cycle();
      checks++;
      if (io.u_out !== 5'(exp_u[k]) || io.axon !== exp_a[k]) begin
        errors++;
        $display("FAIL fire[%0d] got u=%0d axon=%b want u=%0d axon=%b",
                 k, io.u_out, io.axon, exp_u[k], exp_a[k]);
      end
    end
  endtask

  task automatic test_inhibit_floor();
    logic [2:0] d [4] = '{3'b001, 3'b010, 3'b001, 3'b011};
    int exp_u [4] = '{3, 0, 3, 2};
    setup(3, -4, 0, 31, 0, 0);
    for (int k = 0; k < 4; k++) begin
      io.dend = d[k];
      cycle();
      checks++;
      if (io.u_out !== 5'(exp_u[k]) || io.axon !== 1'b0) begin
        errors++;
        $display("FAIL inhibit[%0d] got u=%0d axon=%b want u=%0d axon=0",
                 k, io.u_out, io.axon, exp_u[k]);
      end
    end
  endtask

  task automatic test_leak();
    logic [7:0] db [5] = '{8'h04, 8'h04, 8'h04, 8'h00, 8'h04};
    int exp_u [5] = '{4, 4, 4, 4, 2};
    setup(3, 0, 0, 31, 0, 2);
    io.dend = 3'b001;
    repeat (3) cycle();
    io.dend = '0;
    checks++;
    if (io.u_out !== 5'd9) begin
      errors++;
      $display("FAIL leak_pre got u=%0d want 9", io.u_out);
    end
    for (int k = 0; k < 5; k++) begin
      io.dbus = db[k];
      cycle();
      checks++;
      if (io.u_out !== 5'(exp_u[k])) begin
        errors++;
        $display("FAIL leak[%0d] got u=%0d want %0d", k, io.u_out, exp_u[k]);
      end
    end
    io.dbus = '0;
  endtask

  task automatic test_refractory_clear();
    int exp_u [8] = '{3, 0, 0, 0, 3, 0, 3, 0};
    bit exp_a [8] = '{0, 1, 0, 0, 0, 0, 0, 1};
    bit clr   [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    setup(3, 0, 0, 4, 2, 0);
    io.dend = 3'b001;
    for (int k = 0; k < 8; k++) begin
      io.nn_clear = clr[k];
      cycle();
      checks++;
      if (io.u_out !== 5'(exp_u[k]) || io.axon !== exp_a[k]) begin
        errors++;
        $display("FAIL refr_clr[%0d] got u=%0d axon=%b want u=%0d axon=%b",
                 k, io.u_out, io.axon, exp_u[k], exp_a[k]);
      end
    end
    io.nn_clear = 1'b0;
    io.dend = '0;
  endtask

  task automatic test_thresh_zero();
    setup(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      io.dend = 3'($urandom_range(0, 7));
      cycle();
      checks++;
      if (io.axon !== 1'b1 || io.u_out !== 5'd0) begin
        errors++;
        $display("FAIL thr0[%0d] got axon=%b u=%0d want 1 0", k, io.axon, io.u_out);
      end
    end
    io.dend = '0;
  endtask

  task automatic test_chain();
    bit [18:0] pat;
    setup(3, 0, 0, 31, 0, 0);
    io.dend = 3'b001;
    repeat (2) cycle();
    pat = 19'($urandom);
    io.conf_en = 1'b1;
    for (int i = 18; i >= 0; i--) begin
      io.bs_in = pat[i];
      cycle();
      checks++;
      if (io.u_out !== 5'd6 || io.axon !== 1'b0) begin
        errors++;
        $display("FAIL chain_freeze got u=%0d axon=%b want 6 0", io.u_out, io.axon);
      end
    end
    io.bs_in = 1'b0;
    for (int k = 0; k < 19; k++) begin
      checks++;
      if (io.bs_out !== pat[18 - k]) begin
        errors++;
        $display("FAIL chain_replay[%0d] got %b want %b", k, io.bs_out, pat[18 - k]);
      end
      cycle();
    end
    checks++;
    if (io.bs_out !== 1'b0 || io.u_out !== 5'd6) begin
      errors++;
      $display("FAIL chain_end got bs_out=%b u=%0d want 0 6", io.bs_out, io.u_out);
    end
    io.conf_en = 1'b0;
    io.dend = '0;
  endtask

  task automatic test_reset_midstate();
    setup(3, 0, 0, 4, 3, 0);
    io.dend = 3'b001;
    repeat (3) cycle();   // fired and now refractory
    nn_reset = 1'b1;
    cycle();
    nn_reset = 1'b0;
    checks++;
    if (io.axon !== 1'b0 || io.u_out !== 5'd0 || io.bs_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got axon=%b u=%0d bs_out=%b want 0 0 0", io.axon, io.u_out, io.bs_out);
    end
    // Config is all zero now: thresh 0, no refractory left -> fires at once.
    cycle();
    checks++;
    if (io.axon !== 1'b1) begin
      errors++;
      $display("FAIL reset_cfg_gone got axon=%b want 1", io.axon);
    end
    io.dend = '0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 2000; n++) begin
      if (n % 250 == 0) load_cfg(19'($urandom));
      io.dend     = 3'($urandom_range(0, 7));
      io.dbus     = 8'($urandom);
      io.nn_clear = ($urandom_range(0, 31) == 0);
      io.conf_en  = ($urandom_range(0, 49) == 0);
      io.bs_in    = 1'($urandom);
      nn_reset    = ($urandom_range(0, 399) == 0);
      cycle();
      checks++;
      if (io.u_out !== 5'(m_u) || io.axon !== m_axon || io.bs_out !== m_cfg[18]) begin
        errors++;
        $display("FAIL random[%0d] got u=%0d axon=%b bs=%b want u=%0d axon=%b bs=%b",
                 n, io.u_out, io.axon, io.bs_out, m_u, m_axon, m_cfg[18]);
      end
    end
    nn_reset = 1'b0; io.nn_clear = 1'b0; io.conf_en = 1'b0;
  endtask

  initial begin
    nn_reset = 1'b0;
    io.conf_en = 1'b0; io.bs_in = 1'b0; io.nn_clear = 1'b0;
    io.dend = '0; io.dbus = '0;
    #2;
    test_reset();
    test_fire();
    test_inhibit_floor();
    test_leak();
    test_refractory_clear();
    test_thresh_zero();
    test_chain();
    test_reset_midstate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
